// File: rtl/register_file_pkg.sv
// Shared register-file definitions: register address map and the
// operation encoding used by the command sequencer.
package register_file_pkg;

  localparam int NUM_GPR   = 4;
  localparam int GPR_IDX_W = 2;

  localparam logic [3:0] REG_R0  = 4'h0;
  localparam logic [3:0] REG_R1  = 4'h1;
  localparam logic [3:0] REG_R2  = 4'h2;
  localparam logic [3:0] REG_R3  = 4'h3;
  localparam logic [3:0] REG_ACC = 4'h8;

  typedef enum logic [1:0] {
    RF_OP_LDI  = 2'b00,
    RF_OP_PUT  = 2'b01,
    RF_OP_GET  = 2'b10,
    RF_OP_READ = 2'b11
  } rf_op_e;

endpackage

// File: rtl/register_file_ctrl_if.sv
// Command and response channels between an initiator (decoder or debug
// master) and the register-file command sequencer.
interface register_file_ctrl_if
  import register_file_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int REG_ADDR_WIDTH = 4
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  rf_op_e                    cmd_op;
  logic [REG_ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_W-1:0]         cmd_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/register_file.sv
// Accumulator plus a small bank of general registers. Reserved addresses
// read as zero and ignore writes; storage is data only and carries no reset.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic [DATA_W-1:0]         acc_in,
  input  logic                      acc_write_enable,
  input  logic                      write_put_acc,
  input  logic                      read_get_to_acc,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic                      read_data_output_enable,
  output logic [DATA_W-1:0]         read_data,
  output logic [DATA_W-1:0]         acc_out
);
  logic [DATA_W-1:0]    acc;
  logic [DATA_W-1:0]    regs [NUM_GPR];
  logic [DATA_W-1:0]    rd_val;
  logic                 is_gpr;
  logic [GPR_IDX_W-1:0] idx;

  assign is_gpr  = (reg_addr < REG_ADDR_WIDTH'(NUM_GPR));
  assign idx     = reg_addr[GPR_IDX_W-1:0];
  assign acc_out = acc;

  always_ff @(posedge clk) begin
    if (acc_write_enable)
      acc <= acc_in;
    else if (read_get_to_acc && is_gpr)
      acc <= regs[idx];
    if (write_put_acc && is_gpr)
      regs[idx] <= acc;
  end

  always_comb begin
    rd_val = '0;
    if (is_gpr)
      rd_val = regs[idx];
    else if (reg_addr == REG_ADDR_WIDTH'(REG_ACC))
      rd_val = acc;
  end

  // Undriven bus reads as zero rather than floating.
  assign read_data = read_data_output_enable ? rd_val : '0;
endmodule

// File: rtl/register_file_ctrl.sv
// Register-file command sequencer: one command at a time becomes a single
// registered strobe cycle (EXEC); READ results are held on the response channel.
module register_file_ctrl
  import register_file_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  register_file_ctrl_if.slave       host,
  output logic [DATA_W-1:0]         acc_in,
  output logic                      acc_write_enable,
  output logic                      write_put_acc,
  output logic                      read_get_to_acc,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic                      read_data_output_enable,
  input  logic [DATA_W-1:0]         read_data
);
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

  state_e            state, state_nxt;
  rf_op_e            op_p1;
  logic [DATA_W-1:0] rsp_data_p2;
  logic              accept;

  assign accept         = host.cmd_valid && (state == ST_IDLE);
  assign host.cmd_ready = (state == ST_IDLE);
  assign host.rsp_valid = (state == ST_RESP);
  assign host.rsp_data  = rsp_data_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (host.cmd_valid) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = (op_p1 == RF_OP_READ) ? ST_RESP : ST_IDLE;
      ST_RESP: if (host.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_p1                   <= RF_OP_LDI;
      acc_in                  <= '0;
      reg_addr                <= '0;
      acc_write_enable        <= 1'b0;
      write_put_acc           <= 1'b0;
      read_get_to_acc         <= 1'b0;
      read_data_output_enable <= 1'b0;
      rsp_data_p2             <= '0;
    end else begin
      acc_write_enable        <= 1'b0;
      write_put_acc           <= 1'b0;
      read_get_to_acc         <= 1'b0;
      read_data_output_enable <= 1'b0;
      // accept -> EXEC: strobes are only ever raised here, so they last one cycle
      if (accept) begin
        op_p1    <= host.cmd_op;
        reg_addr <= host.cmd_addr;
        unique case (host.cmd_op)
          RF_OP_LDI: begin
            acc_write_enable <= 1'b1;
            acc_in           <= host.cmd_data;
          end
          RF_OP_PUT:  write_put_acc           <= 1'b1;
          RF_OP_GET:  read_get_to_acc         <= 1'b1;
          RF_OP_READ: read_data_output_enable <= 1'b1;
        endcase
      end
      // EXEC -> RESP: capture the bus while output-enable is still asserted
      if (state == ST_EXEC && op_p1 == RF_OP_READ)
        rsp_data_p2 <= read_data;
    end
  end
endmodule

// File: tb/tb_register_file_ctrl.sv
// Bench for register_file_ctrl driving register_file; READ results are
// checked against a queue of expected values filled when commands are issued.
module tb_register_file_ctrl;
  import register_file_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] acc_in, read_data, acc_out;
  logic [3:0] reg_addr;
  logic       acc_write_enable, write_put_acc, read_get_to_acc, read_data_output_enable;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int oe_cnt = 0;
  int accept_cyc = 0;
  logic [7:0] exp_q[$];

  register_file_ctrl_if #(.DATA_W(8), .REG_ADDR_WIDTH(4)) bus ();

  register_file_ctrl #(.DATA_W(8), .REG_ADDR_WIDTH(4)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .host                    (bus.slave),
    .acc_in                  (acc_in),
    .acc_write_enable        (acc_write_enable),
    .write_put_acc           (write_put_acc),
    .read_get_to_acc         (read_get_to_acc),
    .reg_addr                (reg_addr),
    .read_data_output_enable (read_data_output_enable),
    .read_data               (read_data)
  );

  register_file #(.DATA_W(8), .REG_ADDR_WIDTH(4)) u_rf (
    .clk                     (clk),
    .acc_in                  (acc_in),
    .acc_write_enable        (acc_write_enable),
    .write_put_acc           (write_put_acc),
    .read_get_to_acc         (read_get_to_acc),
    .reg_addr                (reg_addr),
    .read_data_output_enable (read_data_output_enable),
    .read_data               (read_data),
    .acc_out                 (acc_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard plus strobe exclusivity watch, sampled mid-cycle.
  always @(negedge clk) begin
    logic [3:0] strobes;
    strobes = {acc_write_enable, write_put_acc, read_get_to_acc, read_data_output_enable};
    if (|strobes) chk("one_strobe", $countones(strobes), 1);
    if (read_data_output_enable) oe_cnt <= oe_cnt + 1;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else                   chk("rsp_data", bus.rsp_data, exp_q.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge inside the EXEC cycle.
  task automatic send(input rf_op_e op, input logic [3:0] addr, input logic [7:0] data);
    int budget = 0;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    accept_cyc    = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    exp_q.push_back(exp);
    send(RF_OP_READ, addr, 8'h00);
    chk({tag, "_oe"}, read_data_output_enable, 1);
    @(negedge clk);
    chk({tag, "_vld_hi"}, bus.rsp_valid, 1);
    @(negedge clk);
    chk({tag, "_vld_lo"}, bus.rsp_valid, 0);
  endtask

  initial begin
    int c0;
    int oe0;
    int drain;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = RF_OP_LDI;
    bus.cmd_addr  = 4'h0;
    bus.cmd_data  = 8'hFF;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_strobes", {acc_write_enable, write_put_acc, read_get_to_acc, read_data_output_enable}, 0);
    chk("rst_acc_in", acc_in, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    bus.cmd_valid = 1'b0;
    reset_n       = 1'b1;
    @(negedge clk);

    send(RF_OP_LDI, 4'h0, 8'hA5);
    chk("ldi_we_hi", acc_write_enable, 1);
    chk("ldi_acc_in", acc_in, 8'hA5);
    chk("exec_not_ready", bus.cmd_ready, 0);
    @(negedge clk);
    chk("ldi_we_lo", acc_write_enable, 0);
    chk("ldi_acc_out", acc_out, 8'hA5);
    chk("idle_ready", bus.cmd_ready, 1);

    send(RF_OP_LDI, 4'h0, 8'h11);
    send(RF_OP_PUT, REG_R1, 8'h00);
    send(RF_OP_LDI, 4'h0, 8'h00);
    send(RF_OP_GET, REG_R1, 8'h00);
    chk("get_addr", reg_addr, REG_R1);
    @(negedge clk);
    chk("get_acc_out", acc_out, 8'h11);

    send(RF_OP_LDI, 4'h0, 8'h3C);
    send(RF_OP_PUT, REG_R2, 8'h00);
    bus.rsp_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send(RF_OP_READ, REG_R2, 8'h00);
    chk("hold_oe", read_data_output_enable, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_vld", bus.rsp_valid, 1);
      chk("hold_data", bus.rsp_data, 8'h3C);
      chk("hold_not_ready", bus.cmd_ready, 0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_done_vld", bus.rsp_valid, 0);
    chk("hold_done_ready", bus.cmd_ready, 1);

    send(RF_OP_LDI, 4'h0, 8'h5A);
    oe0 = oe_cnt;
    send(RF_OP_PUT, REG_R0, 8'h00);
    for (int a = 1; a < 4; a++) begin
      c0 = accept_cyc;
      send(RF_OP_PUT, 4'(a), 8'h00);
      chk("b2b_gap", accept_cyc - c0, 2);
    end
    @(negedge clk);
    chk("b2b_no_oe", oe_cnt - oe0, 0);
    read_chk("b2b_r0", REG_R0, 8'h5A);
    read_chk("b2b_r3", REG_R3, 8'h5A);

    send(RF_OP_LDI, 4'h0, 8'h77);
    send(RF_OP_PUT, REG_R3, 8'h00);
    send(RF_OP_LDI, 4'h0, 8'h55);
    send(RF_OP_PUT, REG_R3, 8'h00);
    chk("abort_put_hi", write_put_acc, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_strobes", {acc_write_enable, write_put_acc, read_get_to_acc, read_data_output_enable}, 0);
    chk("abort_ready", bus.cmd_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_rel", bus.cmd_ready, 1);
    read_chk("abort_r3", REG_R3, 8'h77);
    read_chk("abort_acc", REG_ACC, 8'h55);

    send(RF_OP_LDI, 4'h0, 8'h99);
    read_chk("rd_acc", REG_ACC, 8'h99);
    read_chk("rd_rsvd", 4'hC, 8'h00);

    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    chk("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/register_file_ctrl.md
# register_file_ctrl

Command sequencer that drives the register file's control side, the initiator for the register file's accumulator, PUT/GET and output-enable read interface. It accepts one register operation at a time over a valid/ready command channel and converts it into single-cycle register-file strobes. It returns read data over a valid/ready response channel. It sits between the instruction decoder (or a debug master) and `register_file`.

## Interface
Parameters:
- `DATA_W`, 8, data/accumulator width
- `REG_ADDR_WIDTH`, 4, register address width

Ports:
- `clk`  in  1  clock, rising-edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_op`  in  2  operation, `rf_op_e`
- `cmd_addr`  in  REG_ADDR_WIDTH  target register
- `cmd_data`  in  DATA_W  immediate for LDI
- `rsp_valid`  out  1  read response available
- `rsp_ready`  in  1  consumer takes response
- `rsp_data`  out  DATA_W  captured register value
- `acc_in`  out  DATA_W  to register file
- `acc_write_enable`  out  1  to register file
- `write_put_acc`  out  1  to register file, PUT
- `read_get_to_acc`  out  1  to register file, GET
- `reg_addr`  out  REG_ADDR_WIDTH  to register file
- `read_data_output_enable`  out  1  to register file
- `read_data`  in  DATA_W  from register file, tristate bus

## Operation
- Ops (`rf_op_e`):
  - LDI=2'b00: ACC ← cmd_data
  - PUT=2'b01: reg[cmd_addr] ← ACC
  - GET=2'b10: ACC ← reg[cmd_addr]
  - READ=2'b11: return reg[cmd_addr] on rsp channel
- FSM states:
  - IDLE: `cmd_ready`=1; on accept (`cmd_valid && cmd_ready` at posedge), latch op/addr/data, go to EXEC.
  - EXEC: assert exactly one strobe for the latched op; `reg_addr` = latched addr. LDI/PUT/GET → IDLE. READ → RESP, capturing `read_data` into `rsp_data` at the EXEC-ending edge.
  - RESP: `rsp_valid`=1, `rsp_data` stable; on `rsp_ready` → IDLE.
- All register-file outputs are registered; strobes are never asserted outside EXEC. `read_data_output_enable` is high only in EXEC of a READ.
- Addresses pass through unmodified. Reserved/invalid addresses produce the same strobe sequence, and the register file defines the effect.
- Reset values: state IDLE, `cmd_ready`=1 (`cmd_valid` ignored while `reset_n`=0), all strobes 0, `acc_in`/`reg_addr`/`rsp_data`=0, `rsp_valid`=0.
- Reset mid-operation clears the FSM immediately (async). An in-flight strobe is dropped and a pending response is discarded.
- `cmd_ready`=0 in EXEC and RESP. A `cmd_valid` held there waits and is not lost.

## Timing
- Accept at edge N → strobe high during cycle N..N+1 → register file updates at edge N+1.
- LDI/PUT/GET: back-to-back throughput 1 command per 2 cycles. The next command can be accepted at edge N+2.
- READ: `rsp_valid` rises after edge N+1 (1-cycle latency from accept). It holds until `rsp_ready` at edge M. `cmd_ready` returns after edge M.
- `rsp_valid` and `rsp_ready` both high in the same cycle completes at that edge. Zero-cycle RESP is not allowed.
- PUT issued immediately after LDI sees the new ACC, because the register file updated at the LDI EXEC edge.

## Structure
- Add `typedef enum logic [1:0] rf_op_e` (RF_OP_LDI, RF_OP_PUT, RF_OP_GET, RF_OP_READ) to `register_file_pkg`, alongside the existing REG_* address constants.
- The FSM state enum stays local to the module.
- Single module; no sub-module is needed.
- The bench instantiates `register_file_ctrl` plus `register_file` together.

## Test plan
- Reset then LDI 8'hA5 → `acc_write_enable` high for exactly 1 cycle with `acc_in`=8'hA5; `acc_out`=8'hA5 afterwards.
- LDI 8'h11, PUT REG_R1, LDI 8'h00, GET REG_R1 → `acc_out`=8'h11.
- LDI 8'h3C, PUT REG_R2, READ REG_R2 with `rsp_ready` low 5 cycles → `rsp_valid` high and `rsp_data`=8'h3C held for all 5 cycles; `cmd_ready`=0 throughout; completes on `rsp_ready`.
- `cmd_valid` held continuously with 4 PUTs to R0..R3 → accepts every 2nd cycle; no strobe overlap; `read_data_output_enable` never high.
- Assert `reset_n`=0 during EXEC of a PUT (asynchronously, mid-cycle) → all strobes drop that instant; target register unchanged; `cmd_ready`=1 after release.
- READ REG_ACC after LDI 8'h99 → `rsp_data`=8'h99. READ of reserved address 4'hC → response still returned, with `rsp_valid` pulse exactly as normal.
